// File: rtl/cal_clk_divider.sv
// Programmable calibration clock divider: cal_out = cal_clkin / (2*(N+1)), 50% duty, glitch-free.
// Latency: cal_out is registered; first rising edge on the (N+1)th enabled clock edge after idle.
// Backpressure: none; cal_load is sampled every cycle, running-mode loads are held until a half-period boundary.
module cal_clk_divider #(
    parameter int WIDTH = 6
) (
    input  logic             cal_clkin,
    input  logic             cal_reset,
    input  logic             cal_en,
    input  logic             cal_load,
    input  logic [WIDTH-1:0] cal_divcount,
    output logic             cal_out
);

    // Active divide value, deferred-load holding register and half-period counter.
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] pend_reg;
    logic             pend_flag;
    logic [WIDTH-1:0] cnt;

    // Last cycle of the current half-period while running.
    logic             terminal;
    // Cycles where the active divide value may safely change: idle, or the
    // edge that ends a half-period (so cal_out never sees a shortened phase).
    logic             boundary;
    // Load arriving mid-half-period has to be parked until the next boundary.
    logic             defer_load;

    assign terminal   = cal_en && (cnt == div_reg);
    assign boundary   = !cal_en || terminal;
    assign defer_load = cal_en && !terminal && cal_load;

    // Half-period counter: cleared while idle and at each toggle, otherwise counts up.
    always_ff @(posedge cal_clkin) begin
        if (cal_reset) begin
            cnt <= '0;
        end else if (boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Output flop: forced low while idle, inverted at the end of every half-period.
    always_ff @(posedge cal_clkin) begin
        if (cal_reset) begin
            cal_out <= 1'b0;
        end else if (!cal_en) begin
            cal_out <= 1'b0;
        end else if (terminal) begin
            cal_out <= ~cal_out;
        end
    end

    // Active divide value: a same-cycle load wins over an older pending one.
    always_ff @(posedge cal_clkin) begin
        if (cal_reset) begin
            div_reg <= '0;
        end else if (boundary) begin
            if (cal_load) begin
                div_reg <= cal_divcount;
            end else if (pend_flag) begin
                div_reg <= pend_reg;
            end
        end
    end

    // Pending value: the most recent mid-half-period load overwrites any earlier one.
    always_ff @(posedge cal_clkin) begin
        if (cal_reset) begin
            pend_reg <= '0;
        end else if (defer_load) begin
            pend_reg <= cal_divcount;
        end
    end

    // Pending flag: consumed (or made moot by a direct load) at every boundary.
    always_ff @(posedge cal_clkin) begin
        if (cal_reset) begin
            pend_flag <= 1'b0;
        end else if (boundary) begin
            pend_flag <= 1'b0;
        end else if (defer_load) begin
            pend_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cal_clk_divider.sv
// Self-checking bench for cal_clk_divider: directed scenarios plus randomized traffic.
// Every cycle cal_out is compared against a half-period-length reference model.
// Directed scenarios additionally check against hand-derived waveforms.
module tb_cal_clk_divider;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ld;
    logic [5:0] dc;
    logic       out;

    int n_tests;
    int n_fail;

    // Reference model: current half-period length is (divide value + 1)
    // cycles; cycles_done counts cycles spent in the current phase.
    int m_div;
    int m_pend;
    bit m_pend_v;
    int m_cycles_done;
    bit m_level;

    cal_clk_divider #(.WIDTH(6)) dut (
        .cal_clkin    (clk),
        .cal_reset    (rst),
        .cal_en       (en),
        .cal_load     (ld),
        .cal_divcount (dc),
        .cal_out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit l, input int d);
        int half_len;
        if (r) begin
            m_div = 0; m_pend = 0; m_pend_v = 0; m_cycles_done = 0; m_level = 0;
        end else if (!e) begin
            m_cycles_done = 0;
            m_level = 0;
            if (l) begin
                m_div = d; m_pend_v = 0;
            end else if (m_pend_v) begin
                m_div = m_pend; m_pend_v = 0;
            end
        end else begin
            half_len = m_div + 1;
            if (m_cycles_done + 1 < half_len) begin
                m_cycles_done++;
                if (l) begin
                    m_pend = d; m_pend_v = 1;
                end
            end else begin
                m_cycles_done = 0;
                m_level = !m_level;
                if (l) begin
                    m_div = d; m_pend_v = 0;
                end else if (m_pend_v) begin
                    m_div = m_pend; m_pend_v = 0;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, check cal_out.
    task automatic step(input bit r, input bit e, input bit l, input int d);
        rst = r; en = e; ld = l; dc = 6'(d);
        @(posedge clk);
        model_edge(r, e, l, d);
        #1;
        check("model", {31'b0, out}, {31'b0, m_level});
    endtask

    initial begin
        int exp3[10];
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b0; ld = 1'b0; dc = '0;
        m_div = 0; m_pend = 0; m_pend_v = 0; m_cycles_done = 0; m_level = 0;
        #2;

        // Reset held with enable low, then run with default divide 0.
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, 0);
            check("reset_out", {31'b0, out}, 32'd0);
        end
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 0, 0);
            check("div0_toggle", {31'b0, out}, 32'(k % 2));
        end

        // Idle load of 3, then enable: rise on 4th edge, period 8.
        step(0, 0, 1, 3);
        check("idle_low", {31'b0, out}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 0, 0);
            check("n3_wave", {31'b0, out}, 32'((k / 4) % 2));
        end

        // Mid-half-period load of 1: current phase finishes at 4, then 2-cycle phases.
        exp3 = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
        for (int k = 0; k < 10; k++) begin
            step(0, 1, (k == 1), 1);
            check("defer_load", {31'b0, out}, 32'(exp3[k]));
        end

        // N=5 with a load of 0 exactly on the terminal edge.
        step(0, 0, 1, 5);
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 0, 0);
            check("n5_low", {31'b0, out}, 32'd0);
        end
        step(0, 1, 1, 0);
        check("term_load_toggle", {31'b0, out}, 32'd1);
        step(0, 1, 0, 0);
        check("term_load_next0", {31'b0, out}, 32'd0);
        step(0, 1, 0, 0);
        check("term_load_next1", {31'b0, out}, 32'd1);

        // N=63: period 128, drop enable while high, re-enable.
        step(0, 0, 1, 63);
        for (int k = 1; k <= 193; k++) begin
            step(0, 1, 0, 0);
            if (k == 63 || k == 64 || k == 127 || k == 128 || k == 191 || k == 192 || k == 193)
                check("n63_wave", {31'b0, out}, 32'((k / 64) % 2));
        end
        step(0, 0, 0, 0);
        check("drop_en_low", {31'b0, out}, 32'd0);
        for (int k = 1; k <= 64; k++) begin
            step(0, 1, 0, 0);
            if (k == 63 || k == 64)
                check("n63_reenable", {31'b0, out}, 32'(k / 64));
        end

        // N=7, pending load then reset: pending value must be discarded.
        step(0, 0, 1, 7);
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0, 0);
            if (k == 8 || k == 10)
                check("n7_high", {31'b0, out}, 32'd1);
        end
        step(0, 1, 1, 2);
        check("n7_pend", {31'b0, out}, 32'd1);
        step(1, 1, 0, 0);
        check("mid_reset", {31'b0, out}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 0, 0);
            check("post_reset_div0", {31'b0, out}, 32'(k % 2));
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bit r, e, l;
            int d;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 19) != 0);
            l = ($urandom_range(0, 24) == 0);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
            step(r, e, l, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
